// File: rtl/multi_port_arbiter.sv
// multi_port_arbiter: round-robin / fixed-priority bus arbiter with registered one-hot grant.
// Define ARB_WEIGHT_EN to add per-port weighted burst quotas on weight_i.
module multi_port_arbiter #(
  parameter int N_PORTS = 4,
  parameter int SEL_W = $clog2(N_PORTS),
  parameter int MODE = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [N_PORTS-1:0]   req_i,
  input  logic [N_PORTS-1:0]   last_i,
  input  logic                 ready_i,
  output logic [N_PORTS-1:0]   gnt_o,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 busy_o
`ifdef ARB_WEIGHT_EN
  ,
  input  logic [4*N_PORTS-1:0] weight_i
`endif
);
  localparam int KW = SEL_W + 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_r;
  logic [SEL_W-1:0] ptr_r, ptr_nxt, base, win;
  logic [3:0] quota_r, quota_dec, quota_ld;
  logic fin, rel, keep;

  // first requester at or above p, wrapping at N_PORTS
  function automatic logic [SEL_W-1:0] pick(input logic [N_PORTS-1:0] r, input logic [SEL_W-1:0] p);
    logic [KW-1:0] k;
    logic f;
    pick = '0;
    f = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      k = {1'b0, p} + KW'(i);
      if (k >= KW'(N_PORTS)) k = k - KW'(N_PORTS);
      if (!f && r[k[SEL_W-1:0]]) begin
        pick = k[SEL_W-1:0];
        f = 1'b1;
      end
    end
  endfunction

  always_comb begin
    fin = busy_o & req_i[sel_o] & ready_i & last_i[sel_o];
    rel = busy_o & (fin | ~req_i[sel_o]);
    quota_dec = quota_r - 4'd1;
    keep = (MODE == 0) & fin & (quota_dec != 4'd0);
    ptr_nxt = keep ? ptr_r : (sel_o == SEL_W'(N_PORTS - 1)) ? '0 : sel_o + SEL_W'(1);
    base = (MODE != 0) ? '0 : busy_o ? ptr_nxt : ptr_r;
    win = keep ? sel_o : pick(req_i, base);
`ifdef ARB_WEIGHT_EN
    quota_ld = (weight_i[4*win +: 4] == 4'd0) ? 4'd1 : weight_i[4*win +: 4];
`else
    quota_ld = 4'd1;
`endif
  end

  // release and re-grant share one edge, so back-to-back transactions have no bubble
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= IDLE;
      gnt_o   <= '0;
      sel_o   <= '0;
      busy_o  <= 1'b0;
      ptr_r   <= '0;
      quota_r <= '0;
    end else if (state_r == IDLE ? |req_i : rel) begin
      if (state_r == GRANT) ptr_r <= ptr_nxt;
      if (|req_i) begin
        state_r <= GRANT;
        gnt_o   <= {{(N_PORTS-1){1'b0}}, 1'b1} << win;
        sel_o   <= win;
        busy_o  <= 1'b1;
        quota_r <= keep ? quota_dec : quota_ld;
      end else begin
        state_r <= IDLE;
        gnt_o   <= '0;
        busy_o  <= 1'b0;
        quota_r <= '0;
      end
    end
  end
endmodule

// File: tb/tb_multi_port_arbiter.sv
// tb_multi_port_arbiter: directed scoreboard bench for round-robin and fixed-priority instances.
// Build with ARB_WEIGHT_EN to include the weighted-burst sequence.
module tb_multi_port_arbiter;
  typedef struct packed {
    int         tag;
    logic       id;
    logic [6:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req0, last0, req1, last1, gnt0, gnt1;
  logic rdy0, rdy1, busy0, busy1;
  logic [1:0] sel0, sel1;
  logic [15:0] w;
  exp_t q[$];
  exp_t e;
  int tag = 0;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  multi_port_arbiter #(.N_PORTS(4), .MODE(0)) dut0 (
    .clk_i(clk), .reset_ni(rst_n), .req_i(req0), .last_i(last0), .ready_i(rdy0),
    .gnt_o(gnt0), .sel_o(sel0), .busy_o(busy0)
`ifdef ARB_WEIGHT_EN
    , .weight_i(w)
`endif
  );

  multi_port_arbiter #(.N_PORTS(4), .MODE(1)) dut1 (
    .clk_i(clk), .reset_ni(rst_n), .req_i(req1), .last_i(last1), .ready_i(rdy1),
    .gnt_o(gnt1), .sel_o(sel1), .busy_o(busy1)
`ifdef ARB_WEIGHT_EN
    , .weight_i(w)
`endif
  );

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic ex(input logic id, input logic [3:0] g, input logic [1:0] s, input logic b);
    q.push_back('{tag, id, {b, s, g}});
    tag++;
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // monitor: every expectation pushed before an edge is checked just after it
  always @(posedge clk) begin
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("vec%0d_dut%0d", e.tag, e.id), e.id ? {busy1, sel1, gnt1} : {busy0, sel0, gnt0}, e.v);
    end
    chk("busy_eq_or_gnt0", {6'd0, busy0}, {6'd0, |gnt0});
    chk("onehot0_gnt0", {6'd0, $onehot0(gnt0)}, 7'd1);
    chk("busy_eq_or_gnt1", {6'd0, busy1}, {6'd0, |gnt1});
    chk("onehot0_gnt1", {6'd0, $onehot0(gnt1)}, 7'd1);
  end

  initial begin
    rst_n = 1'b0;
    {req0, last0, req1, last1} = '0;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    w = 16'h0000;
    #1;
    chk("reset_dut0", {busy0, sel0, gnt0}, 7'd0);
    chk("reset_dut1", {busy1, sel1, gnt1}, 7'd0);
    nx(); nx();
    rst_n = 1'b1;
`ifdef ARB_WEIGHT_EN
    w = {4'd1, 4'd1, 4'd1, 4'd3};
    req0 = 4'b1111; last0 = 4'b1111; rdy0 = 1'b1;
    ex(0, 4'b0001, 0, 1); nx();
    ex(0, 4'b0001, 0, 1); nx();
    ex(0, 4'b0001, 0, 1); nx();
    ex(0, 4'b0010, 1, 1); nx();
    ex(0, 4'b0100, 2, 1); nx();
    ex(0, 4'b1000, 3, 1); nx();
    ex(0, 4'b0001, 0, 1); nx();
    req0 = 4'b0000;
    ex(0, 4'b0000, 0, 0); nx();
    rst_n = 1'b0; nx();
    rst_n = 1'b1;
    w = 16'h0000;
`endif
    // round-robin rotation, single-beat transactions
    req0 = 4'b1111; last0 = 4'b1111; rdy0 = 1'b1;
    ex(0, 4'b0001, 0, 1); nx();
    ex(0, 4'b0010, 1, 1); nx();
    ex(0, 4'b0100, 2, 1); nx();
    ex(0, 4'b1000, 3, 1); nx();
    ex(0, 4'b0001, 0, 1); nx();
    req0 = 4'b0000;
    ex(0, 4'b0000, 0, 0); nx();
    // port 2 three-beat burst with two stall cycles
    req0 = 4'b0100; last0 = 4'b0000;
    ex(0, 4'b0100, 2, 1); nx();
    req0 = 4'b1111; last0 = 4'b1011;
    ex(0, 4'b0100, 2, 1); nx();
    rdy0 = 1'b0; last0 = 4'b0100;
    ex(0, 4'b0100, 2, 1); nx();
    last0 = 4'b0000;
    ex(0, 4'b0100, 2, 1); nx();
    rdy0 = 1'b1;
    ex(0, 4'b0100, 2, 1); nx();
    last0 = 4'b0100;
    ex(0, 4'b1000, 3, 1); nx();
    // port 3 ends, port 0 granted then aborts
    last0 = 4'b1000;
    ex(0, 4'b0001, 0, 1); nx();
    req0 = 4'b1110; last0 = 4'b0000;
    ex(0, 4'b0010, 1, 1); nx();
    chk("ptr_after_abort", {5'd0, dut0.ptr_r}, 7'd1);
    req0 = 4'b0000;
    ex(0, 4'b0000, 1, 0); nx();
    // asynchronous reset mid-burst on port 2
    req0 = 4'b0100;
    ex(0, 4'b0100, 2, 1); nx();
    req0 = 4'b1110;
    ex(0, 4'b0100, 2, 1); nx();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_dut0", {busy0, sel0, gnt0}, 7'd0);
    nx();
    rst_n = 1'b1;
    ex(0, 4'b0010, 1, 1); nx();
    req0 = 4'b0000;
    ex(0, 4'b0000, 1, 0); nx();
    // fixed priority instance
    req1 = 4'b1010; last1 = 4'b0000; rdy1 = 1'b1;
    ex(1, 4'b0010, 1, 1); nx();
    ex(1, 4'b0010, 1, 1); nx();
    last1 = 4'b1000;
    ex(1, 4'b0010, 1, 1); nx();
    req1 = 4'b1000;
    ex(1, 4'b1000, 3, 1); nx();
    req1 = 4'b1011;
    ex(1, 4'b0001, 0, 1); nx();
    last1 = 4'b0001;
    ex(1, 4'b0001, 0, 1); nx();
    req1 = 4'b0000;
    ex(1, 4'b0000, 0, 0); nx();
    nx();
    chk("scoreboard_drained", 7'(q.size()), 7'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
